// File: rtl/emu_sched_pkg.sv
// Shared types and defaults for the emulator timestep scheduler.
`ifndef DT_WIDTH
`define DT_WIDTH 8
`endif

package emu_sched_pkg;

    localparam int DT_WIDTH_DEFAULT   = `DT_WIDTH;
    localparam int TIME_WIDTH_DEFAULT = 64;

    typedef logic [DT_WIDTH_DEFAULT-1:0]   dt_t;
    typedef logic [TIME_WIDTH_DEFAULT-1:0] emu_time_t;

    // Scheduler FSM encoding, kept as plain constants for legacy tools.
    typedef logic [1:0] sched_state_t;
    localparam sched_state_t ST_RUN     = 2'd0;
    localparam sched_state_t ST_PAUSED  = 2'd1;
    localparam sched_state_t ST_STOPPED = 2'd2;

    // Timestep issued when nobody is asking for one.
    localparam dt_t DT_MAX_DEFAULT = {DT_WIDTH_DEFAULT{1'b1}};

endpackage

// File: rtl/dt_min_reduce.sv
// Masked minimum of N_REQ timestep requests, built as a balanced binary tree.
// Disabled requesters never win; with nobody enabled min_o is all-ones and
// any_en_o is low.
module dt_min_reduce #(
    parameter int N_REQ    = 4,
    parameter int DT_WIDTH = 8
) (
    input  logic [N_REQ*DT_WIDTH-1:0] dt_req_i,
    input  logic [N_REQ-1:0]          req_en_i,
    output logic [DT_WIDTH-1:0]       min_o,
    output logic                      any_en_o
);

    localparam int LEVELS = (N_REQ > 1) ? $clog2(N_REQ) : 0;
    localparam int P      = 1 << LEVELS;

    logic [P*DT_WIDTH-1:0] req_pad_s;
    logic [P-1:0]          en_pad_s;
    logic [DT_WIDTH-1:0]   node_val_s [2*P];
    logic                  node_vld_s [2*P];

    // Pad inputs to a power of two; padded leaves are disabled.
    always_comb begin
        req_pad_s                         = {(P*DT_WIDTH){1'b0}};
        en_pad_s                          = {P{1'b0}};
        req_pad_s[N_REQ*DT_WIDTH-1:0]     = dt_req_i;
        en_pad_s[N_REQ-1:0]               = req_en_i;
    end

    // Heap-ordered tree: leaves at P..2P-1, node k combines 2k and 2k+1, root is 1.
    always_comb begin
        for (int k = 0; k < 2*P; k++) begin
            node_val_s[k] = {DT_WIDTH{1'b1}};
            node_vld_s[k] = 1'b0;
        end
        for (int i = 0; i < P; i++) begin
            node_val_s[P+i] = req_pad_s[i*DT_WIDTH +: DT_WIDTH];
            node_vld_s[P+i] = en_pad_s[i];
        end
        for (int k = P-1; k >= 1; k--) begin
            node_vld_s[k] = node_vld_s[2*k] | node_vld_s[2*k+1];
            if (node_vld_s[2*k] && (!node_vld_s[2*k+1] || (node_val_s[2*k] <= node_val_s[2*k+1]))) begin
                node_val_s[k] = node_val_s[2*k];
            end else if (node_vld_s[2*k+1]) begin
                node_val_s[k] = node_val_s[2*k+1];
            end else begin
                node_val_s[k] = {DT_WIDTH{1'b1}};
            end
        end
    end

    assign min_o    = node_vld_s[1] ? node_val_s[1] : {DT_WIDTH{1'b1}};
    assign any_en_o = node_vld_s[1];

endmodule

// File: rtl/emu_dt_scheduler.sv
// Central emulator timestep scheduler: issues the minimum requested dt each
// cycle, accumulates absolute emulation time, and handles pause and stop-time.
module emu_dt_scheduler
    import emu_sched_pkg::*;
#(
    parameter int                 N_REQ      = 4,
    parameter int                 DT_WIDTH   = DT_WIDTH_DEFAULT,
    parameter int                 TIME_WIDTH = TIME_WIDTH_DEFAULT,
    parameter logic [DT_WIDTH-1:0] DT_MAX    = {DT_WIDTH{1'b1}}
) (
    input  logic                      __emu_clk,
    input  logic                      __emu_rst_n,
    input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
    input  logic [N_REQ-1:0]          req_en,
    input  logic                      pause_req,
    input  logic                      stop_en,
    input  logic [TIME_WIDTH-1:0]     stop_time,
    output logic [DT_WIDTH-1:0]       __emu_dt,
    output logic [TIME_WIDTH-1:0]     emu_time,
    output logic [N_REQ-1:0]          grant,
    output logic [1:0]                state_o,
    output logic                      done
);

    localparam logic [TIME_WIDTH-1:0] DT_MAX_EXT = {{(TIME_WIDTH-DT_WIDTH){1'b0}}, DT_MAX};

    sched_state_t            state_q, state_d;
    logic [TIME_WIDTH-1:0]   emu_time_q, emu_time_d;
    logic                    done_q, done_d;

    logic [DT_WIDTH-1:0]     min_s;
    logic                    any_en_s;
    logic [DT_WIDTH-1:0]     m_s;
    logic [TIME_WIDTH-1:0]   rem_s;
    logic [DT_WIDTH-1:0]     rem_sat_s;
    logic [DT_WIDTH-1:0]     dt_s;
    logic                    stop_hit_s;
    logic [N_REQ-1:0]        grant_s;

    dt_min_reduce #(
        .N_REQ    (N_REQ),
        .DT_WIDTH (DT_WIDTH)
    ) u_min (
        .dt_req_i (dt_req),
        .req_en_i (req_en),
        .min_o    (min_s),
        .any_en_o (any_en_s)
    );

    // Timestep selection: masked minimum, optionally clamped to the distance left to stop_time.
    always_comb begin
        m_s       = any_en_s ? min_s : DT_MAX;
        rem_s     = stop_time - emu_time_q;
        rem_sat_s = (rem_s > DT_MAX_EXT) ? DT_MAX : rem_s[DT_WIDTH-1:0];
        dt_s      = {DT_WIDTH{1'b0}};
        case (state_q)
            ST_RUN: begin
                if (stop_en) begin
                    dt_s = (rem_sat_s < m_s) ? rem_sat_s : m_s;
                end else begin
                    dt_s = m_s;
                end
            end
            default: dt_s = {DT_WIDTH{1'b0}};
        endcase
    end

    // Grant every enabled requester whose request equals the issued dt (zero-dt requesters while frozen).
    always_comb begin
        grant_s = {N_REQ{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            grant_s[i] = req_en[i] && (dt_req[i*DT_WIDTH +: DT_WIDTH] == dt_s);
        end
    end

    // Next time, stop detection and FSM transitions; stop wins over pause.
    always_comb begin
        emu_time_d = emu_time_q + {{(TIME_WIDTH-DT_WIDTH){1'b0}}, dt_s};
        stop_hit_s = stop_en && ((emu_time_d == stop_time) || (emu_time_q >= stop_time));
        state_d    = state_q;
        case (state_q)
            ST_RUN: begin
                if (stop_hit_s) begin
                    state_d = ST_STOPPED;
                end else if (pause_req) begin
                    state_d = ST_PAUSED;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSED: begin
                if (stop_hit_s) begin
                    state_d = ST_STOPPED;
                end else if (!pause_req) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PAUSED;
                end
            end
            ST_STOPPED: state_d = ST_STOPPED;
            default:    state_d = ST_RUN;
        endcase
        done_d = (state_d == ST_STOPPED);
    end

    // State, time and done registers with synchronous active-low reset.
    always_ff @(posedge __emu_clk) begin
        if (!__emu_rst_n) begin
            state_q    <= ST_RUN;
            emu_time_q <= {TIME_WIDTH{1'b0}};
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            emu_time_q <= emu_time_d;
            done_q     <= done_d;
        end
    end

    assign __emu_dt = dt_s;
    assign grant    = grant_s;
    assign emu_time = emu_time_q;
    assign state_o  = state_q;
    assign done     = done_q;

endmodule

// File: tb/tb_emu_dt_scheduler.sv
// Directed self-checking bench for emu_dt_scheduler (N_REQ=4, DT_WIDTH=8).
module tb_emu_dt_scheduler;
    import emu_sched_pkg::*;

    localparam int DTW = DT_WIDTH_DEFAULT;
    localparam int TW  = TIME_WIDTH_DEFAULT;

    logic            clk;
    logic            rst_n;
    logic [4*DTW-1:0] dt_req;
    logic [3:0]      req_en;
    logic            pause_req;
    logic            stop_en;
    logic [TW-1:0]   stop_time;
    logic [DTW-1:0]  emu_dt;
    logic [TW-1:0]   emu_time;
    logic [3:0]      grant;
    logic [1:0]      state_o;
    logic            done;

    int pass_cnt = 0;
    int total_cnt = 0;

    emu_dt_scheduler #(.N_REQ(4)) dut (
        .__emu_clk   (clk),
        .__emu_rst_n (rst_n),
        .dt_req      (dt_req),
        .req_en      (req_en),
        .pause_req   (pause_req),
        .stop_en     (stop_en),
        .stop_time   (stop_time),
        .__emu_dt    (emu_dt),
        .emu_time    (emu_time),
        .grant       (grant),
        .state_o     (state_o),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        logic [DTW-1:0] exp_dt [4];
        logic [3:0]     exp_gr [4];
        logic [TW-1:0]  exp_tm [4];
        logic [TW-1:0]  base;

        // Reset with all four requesters enabled.
        rst_n     = 1'b0;
        req_en    = 4'b1111;
        dt_req    = {8'd40, 8'd25, 8'd25, 8'd100};
        pause_req = 1'b0;
        stop_en   = 1'b0;
        stop_time = 64'd0;
        tick();
        tick();
        chk("rst_time", emu_time, 64'd0);
        chk("rst_state", {62'd0, state_o}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dt", {56'd0, emu_dt}, 64'd25);
        chk("rst_grant_tie", {60'd0, grant}, 64'd6);
        rst_n = 1'b1;
        tick();
        chk("release_time", emu_time, 64'd25);

        // Mask out the two smallest requesters.
        req_en = 4'b1001;
        #1;
        chk("mask_dt", {56'd0, emu_dt}, 64'd40);
        chk("mask_grant", {60'd0, grant}, 64'd8);
        tick();
        chk("mask_time", emu_time, 64'd65);

        // No requester enabled: DT_MAX every cycle.
        rst_n  = 1'b0;
        req_en = 4'b0000;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("noen_dt", {56'd0, emu_dt}, 64'd255);
            chk("noen_grant", {60'd0, grant}, 64'd0);
            tick();
        end
        chk("noen_time", emu_time, 64'd765);

        // Stop-time clamp: steps 30,30,30 then 10 to land on 100.
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        req_en    = 4'b1111;
        dt_req    = {8'd30, 8'd50, 8'd60, 8'd70};
        stop_en   = 1'b1;
        stop_time = 64'd100;
        exp_dt = '{8'd30, 8'd30, 8'd30, 8'd10};
        exp_gr = '{4'b1000, 4'b1000, 4'b1000, 4'b0000};
        exp_tm = '{64'd30, 64'd60, 64'd90, 64'd100};
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("stop_dt", {56'd0, emu_dt}, {56'd0, exp_dt[c]});
            chk("stop_grant", {60'd0, grant}, {60'd0, exp_gr[c]});
            tick();
            chk("stop_time_seq", emu_time, exp_tm[c]);
            chk("stop_state_seq", {62'd0, state_o}, (c == 3) ? 64'd2 : 64'd0);
        end
        chk("stopped_done", {63'd0, done}, 64'd1);
        chk("stopped_dt", {56'd0, emu_dt}, 64'd0);
        tick();
        chk("stopped_hold_time", emu_time, 64'd100);

        // Reset while stopped.
        rst_n   = 1'b0;
        stop_en = 1'b0;
        tick();
        chk("rerst_time", emu_time, 64'd0);
        chk("rerst_state", {62'd0, state_o}, 64'd0);
        chk("rerst_done", {63'd0, done}, 64'd0);

        // Pause for five cycles; the rising cycle still steps by 7.
        rst_n     = 1'b1;
        dt_req    = {8'd7, 8'd9, 8'd11, 8'd13};
        pause_req = 1'b1;
        #1;
        chk("pause_first_dt", {56'd0, emu_dt}, 64'd7);
        chk("pause_first_grant", {60'd0, grant}, 64'd8);
        tick();
        chk("pause_enter_state", {62'd0, state_o}, 64'd1);
        chk("pause_enter_time", emu_time, 64'd7);
        dt_req = {8'd7, 8'd9, 8'd11, 8'd0};
        for (int c = 1; c <= 5; c++) begin
            pause_req = (c < 5);
            #1;
            chk("paused_dt", {56'd0, emu_dt}, 64'd0);
            chk("paused_zero_grant", {60'd0, grant}, 64'd1);
            tick();
            chk("paused_time", emu_time, 64'd7);
            chk("paused_state", {62'd0, state_o}, (c < 5) ? 64'd1 : 64'd0);
        end
        dt_req = {8'd7, 8'd9, 8'd11, 8'd13};
        #1;
        chk("resume_dt", {56'd0, emu_dt}, 64'd7);
        tick();
        chk("resume_time", emu_time, 64'd14);

        // Remaining distance beyond DT_MAX saturates, then lands exactly.
        base      = emu_time;
        dt_req    = {8'd255, 8'd255, 8'd255, 8'd255};
        stop_en   = 1'b1;
        stop_time = 64'd14 + 64'd256 + 64'd5;
        #1;
        chk("sat_dt", {56'd0, emu_dt}, 64'd255);
        chk("sat_grant", {60'd0, grant}, 64'd15);
        tick();
        chk("sat_time", emu_time, 64'd269);
        chk("sat_tail_dt", {56'd0, emu_dt}, 64'd6);
        chk("sat_tail_grant", {60'd0, grant}, 64'd0);
        tick();
        chk("sat_final_time", emu_time, base + 64'd261);
        chk("sat_final_state", {62'd0, state_o}, 64'd2);
        chk("sat_final_done", {63'd0, done}, 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
